// File: rtl/vram_host_port.sv
// vram_host_port: host-side byte-register port issuing held-level
// read/write requests to the SRAM arbiter, with auto-increment and prefetch.
//
// Ports:
//   clock, resetN          clock, async active-low reset
//   hostRegister           0=ADDR_L 1=ADDR_M 2=CTRL 3=DATA
//   hostWriteStrobe/Data   one-cycle host write
//   hostReadStrobe/Data    one-cycle host read, data registered next cycle
//   hostBusy               request in flight or pending
//   memoryAddress          request address, stable while requested
//   memoryRead/WriteRequest level requests, held until completion
//   memoryWriteData        write byte, stable while requested
//   memoryReadData         read byte, valid with memoryReadComplete
//   memoryRead/WriteComplete one-cycle completion pulses
module vram_host_port #(
  parameter int ADDR_WIDTH    = 17,
  parameter bit AUTOINC_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [1:0]            hostRegister,
  input  logic                  hostWriteStrobe,
  input  logic                  hostReadStrobe,
  input  logic [7:0]            hostWriteData,
  output logic [7:0]            hostReadData,
  output logic                  hostBusy,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic                  memoryReadRequest,
  output logic                  memoryWriteRequest,
  output logic [7:0]            memoryWriteData,
  input  logic [7:0]            memoryReadData,
  input  logic                  memoryReadComplete,
  input  logic                  memoryWriteComplete
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [1:0] R_ADDR_L = 2'd0;
  localparam logic [1:0] R_ADDR_M = 2'd1;
  localparam logic [1:0] R_CTRL   = 2'd2;
  localparam logic [1:0] R_DATA   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [7:0]            mwdata_q, mwdata_d;
  logic [7:0]            wbuf_q, wbuf_d;
  logic [7:0]            rbuf_q, rbuf_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  autoinc_q, autoinc_d;
  logic                  wpend_q, wpend_d;
  logic                  pref_q, pref_d;
  logic                  dirty_q, dirty_d;
  logic                  rv_q, rv_d;
  logic                  ovf_q, ovf_d;
  logic                  busy;

  assign busy = (state_q != IDLE) | wpend_q | pref_q;

  assign hostBusy           = busy;
  assign hostReadData       = rdata_q;
  assign memoryAddress      = maddr_q;
  assign memoryWriteData    = mwdata_q;
  assign memoryWriteRequest = (state_q == WRITE);
  assign memoryReadRequest  = (state_q == READ);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    wbuf_d    = wbuf_q;
    rbuf_d    = rbuf_q;
    rdata_d   = rdata_q;
    autoinc_d = autoinc_q;
    wpend_d   = wpend_q;
    pref_d    = pref_q;
    dirty_d   = dirty_q;
    rv_d      = rv_q;
    ovf_d     = ovf_q;

    // memory side first; host actions below override it
    unique case (state_q)
      IDLE: begin
        if (wpend_q) begin
          state_d  = WRITE;
          maddr_d  = addr_q;
          mwdata_d = wbuf_q;
          wpend_d  = 1'b0;
          dirty_d  = 1'b0;
        end else if (pref_q) begin
          state_d = READ;
          maddr_d = addr_q;
          pref_d  = 1'b0;
          dirty_d = 1'b0;
        end
      end
      WRITE: begin
        if (memoryWriteComplete) begin
          state_d = IDLE;
          if (autoinc_q && !dirty_q) begin
            addr_d = maddr_q + ADDR_ONE;
            pref_d = 1'b1;
          end
        end
      end
      READ: begin
        if (memoryReadComplete) begin
          state_d = IDLE;
          rbuf_d  = memoryReadData;
          // a host address change during the read makes it stale
          if (!(dirty_q || pref_q)) rv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hostWriteStrobe) begin
      unique case (hostRegister)
        R_ADDR_L: begin
          addr_d       = addr_q;
          addr_d[7:0]  = hostWriteData;
        end
        R_ADDR_M: begin
          addr_d       = addr_q;
          addr_d[15:8] = hostWriteData;
        end
        R_CTRL: begin
          addr_d     = addr_q;
          addr_d[16] = hostWriteData[0];
          autoinc_d  = hostWriteData[7];
        end
        R_DATA: begin
          if (!wpend_q) begin
            wbuf_d  = hostWriteData;
            wpend_d = 1'b1;
            rv_d    = 1'b0;
          end else begin
            ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (hostRegister != R_DATA) begin
        pref_d  = 1'b1;
        dirty_d = 1'b1;
        rv_d    = 1'b0;
      end
    end else if (hostReadStrobe) begin
      unique case (hostRegister)
        R_ADDR_L: rdata_d = addr_q[7:0];
        R_ADDR_M: rdata_d = addr_q[15:8];
        R_CTRL: begin
          rdata_d = {autoinc_q, busy, ovf_q, rv_q,
                     3'b000, addr_q[16]};
          ovf_d   = 1'b0;
        end
        R_DATA: begin
          rdata_d = rbuf_q;
          rv_d    = 1'b0;
          if (autoinc_q) begin
            addr_d = addr_d + ADDR_ONE;
            pref_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      wbuf_q    <= '0;
      rbuf_q    <= '0;
      rdata_q   <= '0;
      autoinc_q <= AUTOINC_RESET;
      wpend_q   <= 1'b0;
      pref_q    <= 1'b0;
      dirty_q   <= 1'b0;
      rv_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      wbuf_q    <= wbuf_d;
      rbuf_q    <= rbuf_d;
      rdata_q   <= rdata_d;
      autoinc_q <= autoinc_d;
      wpend_q   <= wpend_d;
      pref_q    <= pref_d;
      dirty_q   <= dirty_d;
      rv_q      <= rv_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vram_host_port.sv
// tb_vram_host_port: scoreboard bench for vram_host_port with a
// transaction-level host model and a latency-randomised memory responder.
module tb_vram_host_port;

  localparam int AW = 17;

  logic          clock = 1'b0;
  logic          resetN;
  logic [1:0]    hostRegister;
  logic          hostWriteStrobe;
  logic          hostReadStrobe;
  logic [7:0]    hostWriteData;
  logic [7:0]    hostReadData;
  logic          hostBusy;
  logic [AW-1:0] memoryAddress;
  logic          memoryReadRequest;
  logic          memoryWriteRequest;
  logic [7:0]    memoryWriteData;
  logic [7:0]    memoryReadData;
  logic          memoryReadComplete;
  logic          memoryWriteComplete;

  vram_host_port #(.ADDR_WIDTH(AW), .AUTOINC_RESET(1'b1)) dut (
    .clock              (clock),
    .resetN             (resetN),
    .hostRegister       (hostRegister),
    .hostWriteStrobe    (hostWriteStrobe),
    .hostReadStrobe     (hostReadStrobe),
    .hostWriteData      (hostWriteData),
    .hostReadData       (hostReadData),
    .hostBusy           (hostBusy),
    .memoryAddress      (memoryAddress),
    .memoryReadRequest  (memoryReadRequest),
    .memoryWriteRequest (memoryWriteRequest),
    .memoryWriteData    (memoryWriteData),
    .memoryReadData     (memoryReadData),
    .memoryReadComplete (memoryReadComplete),
    .memoryWriteComplete(memoryWriteComplete)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } req_t;

  req_t       exp_q[$];
  logic [7:0] rd_q[$];

  logic [7:0] env_mem [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];

  int tests  = 0;
  int failed = 0;
  int stall  = 0;

  logic [AW-1:0] m_addr;
  bit            m_ai;
  bit            m_ovf;
  bit            m_rv;
  logic [7:0]    m_rbuf;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void exp_req(input bit w, input logic [AW-1:0] a,
                                  input logic [7:0] d);
    req_t r;
    r.w = w;
    r.a = a;
    r.d = d;
    exp_q.push_back(r);
  endfunction

  function automatic void m_prefetch();
    exp_req(1'b0, m_addr, 8'h00);
    m_rbuf = ref_mem[m_addr];
    m_rv   = 1'b1;
  endfunction

  function automatic void m_advance();
    m_addr = m_addr + 1'b1;
    m_prefetch();
  endfunction

  function automatic void m_reset();
    m_addr = '0;
    m_ai   = 1'b1;
    m_ovf  = 1'b0;
    m_rv   = 1'b0;
    m_rbuf = 8'h00;
  endfunction

  task automatic host_acc(input logic [1:0] r, input logic w,
                          input logic rd, input logic [7:0] d);
    @(posedge clock);
    #1;
    hostRegister    = r;
    hostWriteStrobe = w;
    hostReadStrobe  = rd;
    hostWriteData   = d;
    @(posedge clock);
    #1;
    hostWriteStrobe = 1'b0;
    hostReadStrobe  = 1'b0;
  endtask

  task automatic quiesce();
    int n;
    n = 0;
    @(negedge clock);
    while (hostBusy && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("quiesce_busy", hostBusy, 0);
  endtask

  // One host access against the model, then wait for the port to settle.
  task automatic op(input logic [1:0] r, input bit w,
                    input logic [7:0] d, input bit both = 1'b0);
    if (w) begin
      if (r == 2'd3) begin
        exp_req(1'b1, m_addr, d);
        ref_mem[m_addr] = d;
        m_rv = 1'b0;
        if (m_ai) m_advance();
      end else begin
        case (r)
          2'd0:    m_addr[7:0]  = d;
          2'd1:    m_addr[15:8] = d;
          default: begin
            m_addr[16] = d[0];
            m_ai       = d[7];
          end
        endcase
        m_rv = 1'b0;
        m_prefetch();
      end
    end else begin
      case (r)
        2'd0: rd_q.push_back(m_addr[7:0]);
        2'd1: rd_q.push_back(m_addr[15:8]);
        2'd2: begin
          rd_q.push_back({m_ai, 1'b0, m_ovf, m_rv, 3'b000, m_addr[16]});
          m_ovf = 1'b0;
        end
        default: begin
          rd_q.push_back(m_rbuf);
          m_rv = 1'b0;
          if (m_ai) m_advance();
        end
      endcase
    end
    host_acc(r, w, !w || both, d);
    quiesce();
  endtask

  // memory responder
  initial begin : responder
    bit            isw;
    int            lat;
    logic [AW-1:0] a;
    memoryReadComplete  = 1'b0;
    memoryWriteComplete = 1'b0;
    memoryReadData      = 8'h00;
    forever begin
      @(negedge clock);
      memoryReadComplete  = 1'b0;
      memoryWriteComplete = 1'b0;
      if (memoryReadRequest || memoryWriteRequest) begin
        isw = memoryWriteRequest;
        a   = memoryAddress;
        lat = (stall != 0) ? stall : int'($urandom_range(0, 3));
        repeat (lat) @(negedge clock);
        if (isw) begin
          if (memoryWriteRequest) env_mem[memoryAddress] = memoryWriteData;
          memoryWriteComplete = 1'b1;
        end else begin
          memoryReadData     = env_mem[a];
          memoryReadComplete = 1'b1;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    req_t          e;
    bit            prev;
    bit            pend_rd;
    logic [AW-1:0] ca;
    logic [7:0]    cd;
    prev    = 1'b0;
    pend_rd = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        prev    = 1'b0;
        pend_rd = 1'b0;
      end else begin
        if (pend_rd) begin
          if (rd_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL host_read_unexpected: got %0h expected none",
                     hostReadData);
          end else begin
            chk("host_read", hostReadData, rd_q.pop_front());
          end
        end
        pend_rd = hostReadStrobe && !hostWriteStrobe;
        if (memoryReadRequest && memoryWriteRequest) begin
          tests++;
          failed++;
          $display("FAIL both_requests: got 11 expected one");
        end
        if ((memoryReadRequest || memoryWriteRequest) && !prev) begin
          ca = memoryAddress;
          cd = memoryWriteData;
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL req_unexpected: got w=%0d a=%0h expected none",
                     memoryWriteRequest, memoryAddress);
          end else begin
            e = exp_q.pop_front();
            chk("req_type", memoryWriteRequest, e.w);
            chk("req_addr", memoryAddress, e.a);
            if (e.w) chk("req_wdata", memoryWriteData, e.d);
          end
        end else if (memoryReadRequest || memoryWriteRequest) begin
          if (memoryAddress !== ca ||
              (memoryWriteRequest && memoryWriteData !== cd)) begin
            tests++;
            failed++;
            $display("FAIL req_stable: got %0h/%0h expected %0h/%0h",
                     memoryAddress, memoryWriteData, ca, cd);
          end
        end
        prev = memoryReadRequest || memoryWriteRequest;
      end
    end
  end

  initial begin : stim
    logic [7:0] v;
    resetN          = 1'b0;
    hostRegister    = 2'd0;
    hostWriteStrobe = 1'b0;
    hostReadStrobe  = 1'b0;
    hostWriteData   = 8'h00;
    for (int i = 0; i < (1 << AW); i++) begin
      v = 8'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[17'h01234] = 8'h5A;
    ref_mem[17'h01234] = 8'h5A;
    m_reset();

    #12;
    chk("reset_outputs",
        {hostReadData, hostBusy, memoryAddress, memoryReadRequest,
         memoryWriteRequest, memoryWriteData}, 0);
    @(posedge clock);
    #1;
    resetN = 1'b1;

    // post-reset CTRL: autoinc set, nothing else
    op(2'd2, 1'b0, 8'h00);
    op(2'd3, 1'b0, 8'h00);

    // address 0x01234 prefetch, CTRL 0x90, DATA 0x5A
    op(2'd0, 1'b1, 8'h34);
    op(2'd1, 1'b1, 8'h12);
    op(2'd2, 1'b1, 8'h80);
    op(2'd2, 1'b0, 8'h00);
    op(2'd3, 1'b0, 8'h00);

    // back-to-back auto-increment writes
    op(2'd0, 1'b1, 8'h10);
    op(2'd1, 1'b1, 8'h00);
    stall = 5;
    exp_req(1'b1, 17'h00010, 8'hAA);
    exp_req(1'b1, 17'h00011, 8'hBB);
    ref_mem[17'h00010] = 8'hAA;
    ref_mem[17'h00011] = 8'hBB;
    m_addr = 17'h00012;
    m_prefetch();
    host_acc(2'd3, 1'b1, 1'b0, 8'hAA);
    host_acc(2'd3, 1'b1, 1'b0, 8'hBB);
    quiesce();
    stall = 0;
    op(2'd0, 1'b0, 8'h00);
    op(2'd2, 1'b0, 8'h00);

    // overflow: third write dropped while first is stalled
    op(2'd2, 1'b1, 8'h00);
    op(2'd0, 1'b1, 8'h40);
    op(2'd1, 1'b1, 8'h02);
    stall = 20;
    exp_req(1'b1, 17'h00240, 8'h11);
    exp_req(1'b1, 17'h00240, 8'h22);
    ref_mem[17'h00240] = 8'h22;
    m_rv  = 1'b0;
    m_ovf = 1'b1;
    host_acc(2'd3, 1'b1, 1'b0, 8'h11);
    repeat (2) @(posedge clock);
    host_acc(2'd3, 1'b1, 1'b0, 8'h22);
    repeat (2) @(posedge clock);
    host_acc(2'd3, 1'b1, 1'b0, 8'h33);
    quiesce();
    stall = 0;
    op(2'd2, 1'b0, 8'h00);
    op(2'd2, 1'b0, 8'h00);

    // wrap at the top of the address space
    op(2'd2, 1'b1, 8'h81);
    op(2'd1, 1'b1, 8'hFF);
    op(2'd0, 1'b1, 8'hFF);
    op(2'd3, 1'b1, 8'h77);
    op(2'd0, 1'b0, 8'h00);
    op(2'd2, 1'b0, 8'h00);

    // simultaneous strobes: write wins, read ignored
    op(2'd3, 1'b1, 8'h3C, 1'b1);

    // address rewrite during an in-flight read
    op(2'd2, 1'b1, 8'h80);
    op(2'd0, 1'b1, 8'h00);
    op(2'd1, 1'b1, 8'h04);
    stall = 10;
    exp_req(1'b0, 17'h00400, 8'h00);
    host_acc(2'd1, 1'b1, 1'b0, 8'h04);
    repeat (2) @(posedge clock);
    rd_q.push_back(8'hC0);
    host_acc(2'd2, 1'b0, 1'b1, 8'h00);
    m_addr = 17'h00500;
    m_prefetch();
    host_acc(2'd1, 1'b1, 1'b0, 8'h05);
    quiesce();
    stall = 0;
    op(2'd3, 1'b0, 8'h00);

    // reset during a stalled write; late completion ignored
    op(2'd2, 1'b1, 8'h00);
    op(2'd0, 1'b1, 8'h33);
    op(2'd1, 1'b1, 8'h03);
    stall = 20;
    exp_req(1'b1, 17'h00333, 8'h99);
    host_acc(2'd3, 1'b1, 1'b0, 8'h99);
    repeat (4) @(posedge clock);
    #3;
    resetN = 1'b0;
    #1;
    chk("async_drop",
        {memoryReadRequest, memoryWriteRequest, hostBusy, memoryAddress},
        0);
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    stall  = 0;
    m_reset();
    repeat (25) @(negedge clock);
    chk("late_cpl_idle",
        {memoryReadRequest, memoryWriteRequest, hostBusy}, 0);
    op(2'd2, 1'b0, 8'h00);
    op(2'd3, 1'b0, 8'h00);
    op(2'd0, 1'b1, 8'h33);
    op(2'd1, 1'b1, 8'h03);
    op(2'd3, 1'b0, 8'h00);

    // randomised traffic
    for (int i = 0; i < 200; i++) begin
      op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         8'($urandom));
    end

    repeat (5) @(negedge clock);
    chk("exp_req_left", exp_q.size(), 0);
    chk("exp_read_left", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vram_host_port.md
Name: vram_host_port

Overview:
- Host-side initiator for the SRAM arbiter's memory request/complete interface.
- Presents a 4-register byte port to the host CPU bus: address low, address mid, address high/control, and data.
- Converts host data-register accesses into held-level read and write requests, with an optional address auto-increment and a one-byte read prefetch.
- Sits between the host bus synchroniser and the memory arbiter; it is the only issuer of CPU-side memory requests.

Parameters:
- ADDR_WIDTH, 17, width of memoryAddress and the internal address register.
- AUTOINC_RESET, 1, reset value of the auto-increment enable bit.

Ports:
- clock  in  1  system clock; all logic is on posedge.
- resetN  in  1  asynchronous, active-low reset.
- hostRegister  in  2  register select: 0 = ADDR_L, 1 = ADDR_M, 2 = CTRL, 3 = DATA.
- hostWriteStrobe  in  1  one-cycle write pulse, already synchronised.
- hostReadStrobe  in  1  one-cycle read pulse, already synchronised.
- hostWriteData  in  8  host write byte.
- hostReadData  out  8  registered read byte, valid the cycle after hostReadStrobe.
- hostBusy  out  1  high while a request is in flight or pending.
- memoryAddress  out  ADDR_WIDTH  request address, held stable for the whole request.
- memoryReadRequest  out  1  level request, held until memoryReadComplete.
- memoryWriteRequest  out  1  level request, held until memoryWriteComplete.
- memoryWriteData  out  8  write byte, held stable for the whole request.
- memoryReadData  in  8  read byte, valid in the cycle memoryReadComplete is high.
- memoryReadComplete  in  1  one-cycle completion pulse.
- memoryWriteComplete  in  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous: all outputs 0; address register = 0; autoinc = AUTOINC_RESET; all flags 0; state IDLE. A request in flight is abandoned and no completion is awaited.
- Register writes:
  - ADDR_L sets addr[7:0]; ADDR_M sets addr[15:8].
  - CTRL bit0 sets addr[16]; CTRL bit7 sets autoinc.
  - Any address write sets prefetchPending and addrDirty, and clears readValid.
- DATA write:
  - If writePending = 0: writeBuf <= byte, writePending <= 1, readValid <= 0.
  - Otherwise the byte is dropped and overflow <= 1 (sticky).
- Register reads, returned next cycle:
  - ADDR_L and ADDR_M return the address bytes.
  - CTRL returns {autoinc, hostBusy, overflow, readValid, 3'b0, addr[16]}. Reading CTRL clears overflow.
  - DATA returns readBuf. If autoinc = 1, addr <= addr+1 and prefetchPending <= 1. readValid <= 0 in all cases.
- Simultaneous strobes: hostWriteStrobe wins and the read strobe is ignored.
- FSM states: IDLE, WRITE, READ.
  - IDLE -> WRITE when writePending. Write has priority over prefetch. Latch memoryAddress <= addr, memoryWriteData <= writeBuf, clear writePending and addrDirty, assert memoryWriteRequest.
  - IDLE -> READ when prefetchPending and !writePending. Latch memoryAddress <= addr, clear prefetchPending and addrDirty, assert memoryReadRequest.
  - WRITE -> IDLE on memoryWriteComplete. Deassert the request that same edge. If autoinc and !addrDirty, addr <= memoryAddress+1 and prefetchPending <= 1.
  - READ -> IDLE on memoryReadComplete. readBuf <= memoryReadData. readValid <= 1 unless addrDirty or prefetchPending was set during the read, in which case readValid stays 0 and the pending prefetch reissues.
- Requests are never withdrawn before completion. An in-flight request ignores later host address changes.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0x1FFFF+1 = 0x00000.
- A host address write in the completion cycle wins over auto-increment.
- hostBusy = (state != IDLE) | writePending | prefetchPending.
- Minimum turnaround: the next request asserts one cycle after completion.
- Latency:
  - DATA write to request assertion: 1 cycle when idle.
  - Address write to read request: 1 cycle.

Test Plan:
- Reset, then write ADDR 0x01234 and wait ~10 cycles -> memoryReadRequest held with memoryAddress=0x01234 until memoryReadComplete; readBuf takes memoryReadData=0x5A; CTRL read returns 0x90.
- autoinc=1, addr=0x00010, DATA writes 0xAA then 0xBB back-to-back -> two writes at 0x10 and 0x11, no overflow, final addr=0x12 with prefetch of 0x12 issued.
- Three DATA writes while the first is stalled 20 cycles -> bytes 1 and 2 written, byte 3 dropped; CTRL read returns overflow=1, and a second CTRL read returns overflow=0.
- autoinc=1, addr=0x1FFFF, DATA write -> write at 0x1FFFF, then prefetch at 0x00000.
- Address rewritten to 0x00500 during an in-flight read of 0x00400 -> memoryAddress stays 0x400 until complete, readValid stays 0, then a read of 0x500 is issued.
- resetN low mid-write -> requests drop asynchronously; after release the FSM is IDLE and a late memoryWriteComplete is ignored.
